// File: rtl/disp_pkg.sv
// Shared codes, anode patterns and conversion-state type for the
// seven-segment scan controller.
package disp_pkg;

   localparam logic [3:0] CODE_H     = 4'hA;
   localparam logic [3:0] CODE_A     = 4'hB;
   localparam logic [3:0] CODE_BLANK = 4'h0;
   localparam logic [3:0] AN_OFF     = 4'b1111;

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} conv_state_e;

   // Double-dabble correction: a nibble of 5 or more would overflow past 9 on the next shift.
   function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

   function automatic logic [3:0] an_sel(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD engine: one shift per clock,
// CNT_W shifts, then a one-cycle COMMIT with done high.
module bin2bcd_seq
   import disp_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [3:0]       hund,
   output logic [3:0]       tens,
   output logic [3:0]       ones
);

   localparam int SC_W = $clog2(CNT_W + 1);

   conv_state_e      state_q;
   logic [11:0]      bcd_q;
   logic [CNT_W-1:0] bin_q;
   logic [SC_W-1:0]  shift_cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [11:0]      bcd_adj;

   assign bcd_adj = {dabble_adj(bcd_q[11:8]), dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0])};

   // start is honoured in IDLE and in COMMIT so a queued value follows with no idle gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bcd_q       <= '0;
         bin_q       <= '0;
         shift_cnt_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            CONV: begin
               {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
               shift_cnt_q    <= shift_cnt_q - SC_W'(1);
               if (shift_cnt_q == SC_W'(1)) begin
                  state_q <= COMMIT;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q     <= CONV;
                  busy_q      <= 1'b1;
                  bin_q       <= bin;
                  bcd_q       <= '0;
                  shift_cnt_q <= SC_W'(CNT_W);
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hund = bcd_q[11:8];
   assign tens = bcd_q[7:4];
   assign ones = bcd_q[3:0];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit common-anode scan controller: BCD conversion with one-deep
// pending slot, display registers, slot prescaler and registered digit mux.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count_in,
   input  logic             count_valid,
   input  logic             full,
   output logic [3:0]       digit_code,
   output logic [3:0]       an,
   output logic             busy
);

   localparam int PS_W = $clog2(SCAN_DIV);

   logic             conv_busy, conv_done;
   logic [3:0]       s_hund, s_tens, s_ones;
   logic             start;
   logic [CNT_W-1:0] start_bin;
   logic             pend_q;
   logic [CNT_W-1:0] pend_val_q;
   logic [3:0]       hund_q, tens_q, ones_q;
   logic [PS_W-1:0]  ps_q;
   logic [1:0]       idx_q;
   logic [3:0]       an_q, code_q, an_d, code_d;

   // A fresh strobe in IDLE beats a stale pending value; in COMMIT only the pending value can start.
   assign start     = conv_busy ? (conv_done && pend_q) : (count_valid || pend_q);
   assign start_bin = (!conv_busy && count_valid) ? count_in : pend_val_q;

   bin2bcd_seq #(.CNT_W(CNT_W)) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (start_bin),
      .busy  (conv_busy),
      .done  (conv_done),
      .hund  (s_hund),
      .tens  (s_tens),
      .ones  (s_ones)
   );

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         hund_q     <= '0;
         tens_q     <= '0;
         ones_q     <= '0;
         ps_q       <= '0;
         idx_q      <= '0;
         an_q       <= AN_OFF;
         code_q     <= CODE_BLANK;
      end else begin
         if (count_valid && conv_busy) begin
            pend_q     <= 1'b1;
            pend_val_q <= count_in;
         end else if (start) begin
            pend_q <= 1'b0;
         end
         if (conv_done) begin
            hund_q <= s_hund;
            tens_q <= s_tens;
            ones_q <= s_ones;
         end
         if (ps_q == PS_W'(SCAN_DIV - 1)) begin
            ps_q  <= '0;
            idx_q <= idx_q + 2'd1;
         end else begin
            ps_q <= ps_q + PS_W'(1);
         end
         an_q   <= an_d;
         code_q <= code_d;
      end
   end

   // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      an_d   = AN_OFF;
      code_d = CODE_BLANK;
      if (full) begin
         if (idx_q == 2'd3) begin
            an_d   = an_sel(idx_q);
            code_d = CODE_H;
         end else if (idx_q == 2'd2) begin
            an_d   = an_sel(idx_q);
            code_d = CODE_A;
         end
      end else begin
         case (idx_q)
            2'd2: if (hund_q != 4'd0) begin
               an_d   = an_sel(idx_q);
               code_d = hund_q;
            end
            2'd1: if (hund_q != 4'd0 || tens_q != 4'd0) begin
               an_d   = an_sel(idx_q);
               code_d = tens_q;
            end
            2'd0: begin
               an_d   = an_sel(idx_q);
               code_d = ones_q;
            end
            default: ;
         endcase
      end
   end

   assign an         = an_q;
   assign digit_code = code_q;
   assign busy       = conv_busy;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SCAN_DIV=4, CNT_W=8: reset, conversions,
// blanking, full mode, pending coalescing and reset mid-conversion.
module tb_disp_scan_ctrl;

   localparam int SD = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] count_in = '0;
   logic          count_valid = 1'b0;
   logic          full = 1'b0;
   logic [3:0]    digit_code, an;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;
   int n;

   disp_scan_ctrl #(.SCAN_DIV(SD), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .count_in    (count_in),
      .count_valid (count_valid),
      .full        (full),
      .digit_code  (digit_code),
      .an          (an),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Edges since reset release; outputs after edge k show slot ((k-1)/SD)%4.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [7:0] exp_out(input int idx, input logic f,
                                          input int h, input int t, input int o);
      logic [3:0] e_an, e_code;
      e_an   = 4'b1111;
      e_code = 4'h0;
      if (f) begin
         if (idx == 3)      begin e_an = 4'b0111; e_code = 4'hA; end
         else if (idx == 2) begin e_an = 4'b1011; e_code = 4'hB; end
      end else begin
         if (idx == 2 && h != 0)                begin e_an = 4'b1011; e_code = 4'(h); end
         else if (idx == 1 && (h != 0 || t != 0)) begin e_an = 4'b1101; e_code = 4'(t); end
         else if (idx == 0)                     begin e_an = 4'b1110; e_code = 4'(o); end
      end
      return {e_an, e_code};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int h, input int t, input int o, input logic f);
      logic [7:0] e;
      e = exp_out(((cyc - 1) / SD) % 4, f, h, t, o);
      check({tag, "_an"},   16'(an),         16'(e[7:4]));
      check({tag, "_code"}, 16'(digit_code), 16'(e[3:0]));
   endtask

   task automatic frame_check(input string tag, input int h, input int t, input int o,
                              input logic f, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk); #1;
         check_out(tag, h, t, o, f);
         check({tag, "_busy"}, 16'(busy), 16'd0);
      end
   endtask

   // Strobe one value; returns at #1 after the sampling edge.
   task automatic pulse(input logic [CW-1:0] v);
      @(posedge clk); #1;
      count_in    = v;
      count_valid = 1'b1;
      @(posedge clk); #1;
      count_valid = 1'b0;
   endtask

   task automatic busy_len(input string tag);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      check(tag, 16'(n), 16'd9);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_an",   16'(an),         16'hF);
      check("rst_code", 16'(digit_code), 16'h0);
      check("rst_busy", 16'(busy),       16'd0);
      #6 rst = 1'b0;
      @(posedge clk); #1;
      check("first_an",   16'(an),         16'hE);
      check("first_code", 16'(digit_code), 16'h0);
      frame_check("idle0", 0, 0, 0, 1'b0, 4 * SD);

      // 205: tens zero stays lit because hund is non-zero
      pulse(8'd205);
      busy_len("busy205");
      frame_check("d205", 2, 0, 5, 1'b0, 4 * SD);

      // 7: leading zeros blanked
      pulse(8'd7);
      busy_len("busy7");
      frame_check("d7", 0, 0, 7, 1'b0, 4 * SD);

      // Full mode and return
      full = 1'b1;
      frame_check("full", 0, 0, 7, 1'b1, 4 * SD);
      full = 1'b0;
      frame_check("unfull", 0, 0, 7, 1'b0, 4 * SD);

      // 100, then 50 and 33 while busy: 50 dropped, 33 follows with no idle gap
      @(posedge clk); #1;
      count_in    = 8'd100;
      count_valid = 1'b1;
      @(posedge clk); #1;
      count_valid = 1'b0;
      for (int i = 0; i <= 24; i++) begin
         check("pend_busy", 16'(busy), 16'(i <= 17));
         if (i >= 10) begin
            if (i <= 18) check_out("pend100", 1, 0, 0, 1'b0);
            else         check_out("pend33",  0, 3, 3, 1'b0);
         end
         if (i == 2) begin
            count_in    = 8'd50;
            count_valid = 1'b1;
         end else if (i == 4) begin
            count_in    = 8'd33;
            count_valid = 1'b1;
         end else begin
            count_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      frame_check("d33", 0, 3, 3, 1'b0, 4 * SD);

      // Reset mid-conversion with a pending value queued
      pulse(8'd205);
      @(posedge clk); #1;
      @(posedge clk); #1;
      count_in    = 8'd77;
      count_valid = 1'b1;
      @(posedge clk); #1;
      count_valid = 1'b0;
      check("mid_busy", 16'(busy), 16'd1);
      #3 rst = 1'b1;
      #1;
      check("arst_an",   16'(an),         16'hF);
      check("arst_code", 16'(digit_code), 16'h0);
      check("arst_busy", 16'(busy),       16'd0);
      @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;
      check("rel_an",   16'(an),         16'hE);
      check("rel_code", 16'(digit_code), 16'h0);
      frame_check("post_rst", 0, 0, 0, 1'b0, 5 * SD);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
